// File: rtl/add_result_queue_if.sv
// Handshake bus between an adder result producer, the result queue and writeback.
interface add_result_queue_if #(parameter int TAG_W = 5);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      in_sum;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

  modport master (
    output in_valid, in_a, in_b, in_sum, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_tag, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sum, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_tag, out_flags
  );
endinterface

// File: rtl/add_result_queue.sv
// Circular FIFO of adder results; NZCV flags are derived at push time and
// stored with the sum and destination tag. Counts writeback stall cycles.
module add_result_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  add_result_queue_if.slave   bus,
  input  logic                flush,
  output logic [15:0]         stall_cnt
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]      sum;
    logic [TAG_W-1:0] tag;
    logic [3:0]       flags;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stall_q, stall_d;
  logic             push, pop;
  entry_t           in_entry;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // {N, Z, C, V}; carry/overflow reconstructed from operand and sum sign bits
  function automatic logic [3:0] calc_flags(input logic [31:0] a, b, s);
    logic n, z, c, v;
    n = s[31];
    z = (s == 32'd0);
    c = (a[31] & b[31]) | ((a[31] | b[31]) & ~s[31]);
    v = (a[31] == b[31]) & (s[31] != a[31]);
    return {n, z, c, v};
  endfunction

  always_comb begin
    bus.in_ready  = (cnt_q < CNT_W'(DEPTH));
    bus.out_valid = (cnt_q != '0);
    push          = bus.in_valid & bus.in_ready;
    pop           = bus.out_valid & bus.out_ready;
    in_entry      = '{sum: bus.in_sum, tag: bus.in_tag,
                      flags: calc_flags(bus.in_a, bus.in_b, bus.in_sum)};
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
    stall_d       = stall_q;
    if (bus.out_valid && !bus.out_ready && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      stall_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
    end
  end

  // Storage is not reset; it is only observable through the head while out_valid
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem_q[wr_ptr_q] <= in_entry;
  end

  assign bus.out_sum   = mem_q[rd_ptr_q].sum;
  assign bus.out_tag   = mem_q[rd_ptr_q].tag;
  assign bus.out_flags = mem_q[rd_ptr_q].flags;
  assign stall_cnt     = stall_q;
endmodule
